calc_sched: RTL and testbench
=============================

Name: calc_sched

Overview:
- Sequencer and arbiter for the shared calculator datapath: the 32-bit ALU and the 16-bit accumulator.
- Two requesters (front-panel button logic on port 0, scripted or host stimulus on port 1) submit operations through a valid/ready handshake.
- The block round-robin arbitrates, drives the ALU with the sign-extended accumulator and operand, writes back the result, and returns a one-cycle response to the winner.
- The accumulator register is owned here; the board LEDs display its value.

Parameters:
- DATA_W, 16, accumulator and operand width.
- ALU_W, 32, ALU operand/result width; DATA_W values are sign-extended to ALU_W.
- OP_W, 4, ALU opcode width.

Ports:
- clc  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit is high in any cycle.
- req_op  in  2*OP_W  ALU opcode; [3:0] is requester 0, [7:4] is requester 1.
- req_operand  in  2*DATA_W  operand per requester, packed the same way.
- req_clr  in  2  per-requester clear command; when set, the opcode and operand are ignored.
- rsp_valid  out  2  one-cycle completion pulse to the granted requester.
- rsp_data  out  DATA_W  accumulator value after the operation; valid while rsp_valid is high.
- rsp_zero  out  1  ALU zero flag captured for that operation; forced to 1 on clear.
- alu_op  out  OP_W  opcode to the ALU.
- alu_op1  out  ALU_W  sign-extended accumulator.
- alu_op2  out  ALU_W  sign-extended latched operand.
- alu_result  in  ALU_W  combinational ALU result.
- alu_zero  in  1  combinational ALU zero flag.
- acc  out  DATA_W  accumulator, also drives the LEDs.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: acc=0, rsp_valid=0, rsp_zero=0, alu_op=0, alu_op1=0, alu_op2=0, state=IDLE, last_grant=1 (so requester 0 wins the first tie).
- States: IDLE, ISSUE, WB, RESP.
- IDLE:
  - Arbiter selects grant among the set req_valid bits, round-robin starting after last_grant.
  - req_ready[grant] is high combinationally, only in IDLE and only when req_valid[grant] is high.
  - On the handshake edge: latch op, operand and clr; set last_grant=grant; go to ISSUE.
- ISSUE:
  - alu_op, alu_op1 and alu_op2 are registered outputs, valid for the entire cycle.
  - alu_op1 = {16{acc[15]},acc}; alu_op2 = sign-extended latched operand.
  - Next state is WB.
- WB:
  - At the closing edge, acc <= clr ? 0 : alu_result[DATA_W-1:0], truncated so overflow wraps.
  - At the same edge, rsp_zero <= clr ? 1 : alu_zero.
  - Next state is RESP.
  - The ALU inputs are held stable through WB so that alu_result is sampled from stable inputs.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle; rsp_data = acc.
  - There is no backpressure on responses.
  - Next state is IDLE.
- Latency: accept edge at cycle T; response pulse in cycle T+3; new accept possible in cycle T+4.
- Throughput: one operation per 4 cycles.
- Both requests valid in the same cycle: the non-last_grant requester wins. The loser's req_ready stays low, and it must hold valid, op and operand stable until accepted (protocol rule, asserted in the bench).
- A request raised while busy is ignored until IDLE; no queueing.
- A clear is sequenced through the same four states as an ALU op, so latency is uniform and acc=0 is visible from T+3.
- Reset asserted mid-operation:
  - Immediately returns to IDLE, acc=0, rsp_valid=0.
  - The in-flight operation is dropped with no response.
  - last_grant returns to 1.
- Outside ISSUE/WB, the ALU outputs hold their last values; the ALU result is ignored.
- req_valid deasserted without a handshake has no effect.

Decomposition:
- calc_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_ISSUE=2'd1, S_WB=2'd2, S_RESP=2'd3;
  - the ALU opcode constants ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_XOR, shared with the ALU and the button encoder;
  - DATA_W and ALU_W defaults.
- One sub-module, rr_arb2: 2-way round-robin arbiter. Inputs are req[1:0] and last_grant; outputs are grant and grant_valid. Purely combinational.
- The sign extension reuses the existing 16-to-32 sign-extend cell.

Test Plan:
- Reset, then requester 0 sends ALUOP_ADD with operand 16'h0005 → req_ready[0] is high in the request cycle; rsp_valid[0] pulses 3 cycles after accept; rsp_data=acc=16'h0005; rsp_zero=0.
- Set acc=16'h0005, then ALUOP_SUB with operand 16'h0005 → acc=16'h0000 and rsp_zero=1. Next, ALUOP_SUB with operand 16'h0001 → acc=16'hFFFF; alu_op1 was 32'h00000000 and alu_op2 was 32'h00000001 during ISSUE.
- Both requesters valid in the same cycle, held continuously for 4 operations → grants alternate 0,1,0,1; req_ready is never high for both bits at once; each rsp_valid goes to the matching requester.
- Set acc=16'h7FFF, then ALUOP_ADD with operand 16'h0001 → acc wraps to 16'h8000. A following clear from requester 1 → acc=16'h0000, rsp_zero=1, rsp_valid[1] pulses.
- Assert rst_n low during the WB cycle of an ADD of 16'h1234 → acc=0, no rsp_valid pulse, busy=0 asynchronously. After release, requester 0 wins a simultaneous tie.
- Requester 1 raises valid while the block is busy → req_ready[1] stays low until IDLE; the request is accepted in the first IDLE cycle with its held operand.

Source files
------------

// File: rtl/calc_sched_pkg.sv
// Shared constants for the calculator datapath: default widths, sequencer states
// and ALU opcodes (also used by the ALU and the button encoder).
package calc_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ALU_W  = 32;
  localparam int DEF_OP_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [DEF_OP_W-1:0] ALUOP_ADD = 4'd0;
  localparam logic [DEF_OP_W-1:0] ALUOP_SUB = 4'd1;
  localparam logic [DEF_OP_W-1:0] ALUOP_AND = 4'd2;
  localparam logic [DEF_OP_W-1:0] ALUOP_OR  = 4'd3;
  localparam logic [DEF_OP_W-1:0] ALUOP_XOR = 4'd4;
endpackage

// File: rtl/calc_sched_if.sv
// Request/response bundle between the two requesters and the calculator sequencer.
interface calc_sched_if #(
  parameter int DATA_W = calc_pkg::DEF_DATA_W,
  parameter int OP_W   = calc_pkg::DEF_OP_W
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*OP_W-1:0]   req_op;
  logic [2*DATA_W-1:0] req_operand;
  logic [1:0]          req_clr;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_zero;

  modport master (
    output req_valid, req_op, req_operand, req_clr,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_operand, req_clr,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/calc_sched_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);
  always_comb begin
    grant_valid = |req;
    if (&req) grant = ~last_grant;
    else      grant = req[1];
  end
endmodule

// File: rtl/calc_sched.sv
// Arbitrates two requesters onto the shared ALU, owns the accumulator and returns
// a one-cycle response to the winner; one operation every four cycles.
//
// state   | meaning
// S_IDLE  | arbitrate, accept one request, latch op/operand/clear into ALU regs
// S_ISSUE | ALU inputs presented from registers
// S_WB    | ALU inputs held; accumulator and zero flag written at closing edge
// S_RESP  | one-cycle rsp_valid pulse to the granted requester
module calc_sched import calc_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ALU_W  = DEF_ALU_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clc,
  input  logic              rst_n,
  calc_sched_if.slave       bus,
  output logic [OP_W-1:0]   alu_op,
  output logic [ALU_W-1:0]  alu_op1,
  output logic [ALU_W-1:0]  alu_op2,
  input  logic [ALU_W-1:0]  alu_result,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] acc,
  output logic              busy
);
  localparam int EXT_W = ALU_W - DATA_W;

  state_t              state, state_nxt;
  logic                last_grant, grant, grant_valid, accept, clr_q, rsp_zero;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_operand;
  logic                unused_alu_hi;

  rr_arb2 u_arb (
    .req         (bus.req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign sel_op      = grant ? bus.req_op[2*OP_W-1:OP_W] : bus.req_op[OP_W-1:0];
  assign sel_operand = grant ? bus.req_operand[2*DATA_W-1:DATA_W] : bus.req_operand[DATA_W-1:0];
  assign accept      = (state == S_IDLE) && grant_valid;
  assign busy        = (state != S_IDLE);
  assign bus.rsp_data = acc;
  assign bus.rsp_zero = rsp_zero;
  // Upper result bits are dropped on purpose: the accumulator wraps at DATA_W.
  assign unused_alu_hi = ^alu_result[ALU_W-1:DATA_W];

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          bus.req_ready[grant] = 1'b1;
          state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WB;
      S_WB:    state_nxt = S_RESP;
      S_RESP: begin
        bus.rsp_valid[last_grant] = 1'b1;
        state_nxt                 = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      clr_q      <= 1'b0;
      alu_op     <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      acc        <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        clr_q      <= bus.req_clr[grant];
        alu_op     <= sel_op;
        alu_op1    <= {{EXT_W{acc[DATA_W-1]}}, acc};
        alu_op2    <= {{EXT_W{sel_operand[DATA_W-1]}}, sel_operand};
      end
      if (state == S_WB) begin
        acc      <= clr_q ? '0 : alu_result[DATA_W-1:0];
        rsp_zero <= clr_q | alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_calc_sched.sv
// Bench for calc_sched: table of operations plus tie, busy and mid-operation reset
// sequences, with a cycle-level monitor and response scoreboard.
module tb_calc_sched;
  import calc_pkg::*;

  logic        clc = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        alu_zero;
  logic [15:0] acc;
  logic        busy;

  always #5 clc = ~clc;

  calc_sched_if bus ();

  calc_sched dut (
    .clc        (clc),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .acc        (acc),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_AND: return a & b;
      ALUOP_OR:  return a | b;
      ALUOP_XOR: return a ^ b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Environment ALU
  always_comb begin
    alu_result = alu_ref(alu_op, alu_op1, alu_op2);
    alu_zero   = (alu_result == 32'd0);
  end

  // Loser of an arbitration must hold its request stable until accepted
  for (genvar r = 0; r < 2; r++) begin : g_hold
    assert property (@(posedge clc) disable iff (!rst_n)
      (bus.req_valid[r] && !bus.req_ready[r]) |=>
        (bus.req_valid[r] && $stable(bus.req_op[r*4 +: 4]) && $stable(bus.req_operand[r*16 +: 16])
         && $stable(bus.req_clr[r])));
  end

  typedef struct {
    logic        idx;
    logic [15:0] data;
    logic        zero;
  } exp_t;
  exp_t sb_q[$];

  int          m_phase = 0;
  logic        m_last  = 1'b1;
  logic [15:0] m_acc   = 16'h0000;
  logic        e_clr;
  logic [3:0]  e_op;
  logic [31:0] e_op1, e_op2;

  // Cycle model of the sequencer; pushes expectations at accept, pops at response
  always @(negedge clc) begin : monitor
    logic        g;
    int          gi;
    logic [1:0]  exp_ready;
    logic [31:0] r;
    logic [15:0] opd;
    exp_t        e;
    if (!rst_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_acc   = 16'h0000;
      sb_q.delete();
      chk("rst_acc", 32'(acc), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_zero", 32'(bus.rsp_zero), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_alu_op1", alu_op1, 0);
      chk("rst_alu_op2", alu_op2, 0);
    end else begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      case (m_phase)
        0: begin
          g         = (bus.req_valid == 2'b11) ? ~m_last : bus.req_valid[1];
          gi        = int'(g);
          exp_ready = (bus.req_valid != 2'b00) ? (2'b01 << gi) : 2'b00;
          chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
          chk("idle_busy", 32'(busy), 0);
          chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
          if (exp_ready != 2'b00) begin
            e_clr  = bus.req_clr[gi];
            e_op   = bus.req_op[gi*4 +: 4];
            opd    = bus.req_operand[gi*16 +: 16];
            e_op1  = sx(m_acc);
            e_op2  = sx(opd);
            r      = alu_ref(e_op, e_op1, e_op2);
            e.idx  = g;
            e.data = e_clr ? 16'h0000 : r[15:0];
            e.zero = e_clr ? 1'b1 : (r == 32'd0);
            m_acc  = e.data;
            sb_q.push_back(e);
            m_last  = g;
            m_phase = 1;
          end
        end
        1, 2: begin
          chk("op_busy", 32'(busy), 1);
          chk("op_ready_low", 32'(bus.req_ready), 0);
          chk("op_rsp_low", 32'(bus.rsp_valid), 0);
          if (!e_clr) begin
            chk("alu_op", 32'(alu_op), 32'(e_op));
            chk("alu_op1", alu_op1, e_op1);
            chk("alu_op2", alu_op2, e_op2);
          end
          m_phase++;
        end
        default: begin
          chk("resp_busy", 32'(busy), 1);
          chk("resp_ready_low", 32'(bus.req_ready), 0);
          if (sb_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(2'b01 << int'(e.idx)));
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            chk("resp_acc", 32'(acc), 32'(e.data));
          end
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic issue(input int idx, input logic [3:0] op, input logic [15:0] opd, input bit clr);
    int n;
    @(posedge clc); #1;
    bus.req_op[idx*4 +: 4]       = op;
    bus.req_operand[idx*16 +: 16] = opd;
    bus.req_clr[idx]             = clr;
    bus.req_valid[idx]           = 1'b1;
    n = 0;
    do begin @(negedge clc); n++; end while (bus.req_ready[idx] !== 1'b1 && n < 20);
    if (n >= 20) chk("accept_timeout", 32'(n), 0);
    @(posedge clc); #1;
    bus.req_valid[idx] = 1'b0;
    bus.req_clr[idx]   = 1'b0;
    n = 0;
    do begin @(negedge clc); n++; end while (bus.req_valid[idx] == 1'b0 && bus.rsp_valid[idx] !== 1'b1 && n < 10);
    chk("rsp_latency", 32'(n), 3);
  endtask

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [15:0] opd;
    bit          clr;
    logic [15:0] exp_acc;
    bit          exp_zero;
  } vec_t;
  vec_t vecs[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   n, k, cnt;
    logic gseq[5];
    logic exp_seq[5];

    vecs[0]  = '{0, ALUOP_ADD, 16'h0005, 1'b0, 16'h0005, 1'b0};
    vecs[1]  = '{0, ALUOP_SUB, 16'h0005, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{0, ALUOP_SUB, 16'h0001, 1'b0, 16'hFFFF, 1'b0};
    vecs[3]  = '{1, ALUOP_ADD, 16'hDEAD, 1'b1, 16'h0000, 1'b1};
    vecs[4]  = '{1, ALUOP_ADD, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
    vecs[5]  = '{0, ALUOP_ADD, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[6]  = '{1, ALUOP_XOR, 16'h1234, 1'b1, 16'h0000, 1'b1};
    vecs[7]  = '{0, ALUOP_OR,  16'h00F0, 1'b0, 16'h00F0, 1'b0};
    vecs[8]  = '{1, ALUOP_AND, 16'h0F00, 1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{0, ALUOP_XOR, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
    vecs[10] = '{1, ALUOP_ADD, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{0, ALUOP_SUB, 16'h8000, 1'b0, 16'h8000, 1'b0};
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1; exp_seq[4] = 1'b0;

    bus.req_valid   = 2'b00;
    bus.req_op      = '0;
    bus.req_operand = '0;
    bus.req_clr     = 2'b00;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clc);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].idx, vecs[i].op, vecs[i].opd, vecs[i].clr);
      chk($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
      chk($sformatf("vec%0d_zero", i), 32'(bus.rsp_zero), 32'(vecs[i].exp_zero));
    end

    // Requester 1 raises valid while busy; accepted in first IDLE cycle
    @(posedge clc); #1;
    bus.req_op[3:0] = ALUOP_ADD; bus.req_operand[15:0] = 16'h0001; bus.req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clc); n++; end while (!bus.req_ready[0] && n < 20);
    @(posedge clc); #1;
    bus.req_valid[0] = 1'b0;
    bus.req_op[7:4] = ALUOP_ADD; bus.req_operand[31:16] = 16'h0010; bus.req_valid[1] = 1'b1;
    n = 0;
    do begin @(negedge clc); n++; end while (!bus.req_ready[1] && n < 20);
    chk("busy_accept_wait", 32'(n), 4);
    @(posedge clc); #1;
    bus.req_valid[1] = 1'b0;
    repeat (3) @(negedge clc);
    chk("busy_final_acc", 32'(acc), 32'h8011);

    // Reset during WB of an ADD 0x1234
    @(posedge clc); #1;
    bus.req_op[3:0] = ALUOP_ADD; bus.req_operand[15:0] = 16'h1234; bus.req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clc); n++; end while (!bus.req_ready[0] && n < 20);
    @(posedge clc); #1;
    bus.req_valid[0] = 1'b0;
    @(posedge clc); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_acc", 32'(acc), 0);
    chk("rstmid_rsp", 32'(bus.rsp_valid), 0);
    @(posedge clc); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clc);
      if (bus.rsp_valid != 2'b00) cnt++;
    end
    chk("rstmid_no_rsp", 32'(cnt), 0);

    // Tie held continuously: grants alternate starting with requester 0
    @(posedge clc); #1;
    bus.req_op      = {ALUOP_ADD, ALUOP_ADD};
    bus.req_operand = {16'h0002, 16'h0001};
    bus.req_valid   = 2'b11;
    k = 0; n = 0;
    while (k < 5 && n < 60) begin
      @(negedge clc); n++;
      if (bus.req_ready != 2'b00) begin
        gseq[k] = bus.req_ready[1];
        k++;
        if (k >= 4) begin
          @(posedge clc); #1;
          bus.req_valid[int'(gseq[k-1])] = 1'b0;
        end
      end
    end
    chk("tie_count", 32'(k), 5);
    for (int j = 0; j < 5; j++) chk($sformatf("tie_grant%0d", j), 32'(gseq[j]), 32'(exp_seq[j]));
    repeat (3) @(negedge clc);
    chk("tie_final_acc", 32'(acc), 32'h0007);

    repeat (3) @(negedge clc);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
